data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Data-memory access sequencer that sits directly downstream of the memory data register and memory address register. On a one-cycle read or write request from the control unit, it latches the current address and data, drives a single-port synchronous data RAM through a fixed number of wait states, and returns read data with a completion pulse. Read data is presented for loading into the data register or onto the bus.

## Interface
Parameters:
- ADDR_W, 16, width of data-memory address
- DATA_W, 16, width of data word
- WAIT_CYCLES, 2, extra cycles the RAM strobe is held (0–15 legal)
- MEM_DEPTH, 4096, number of valid words (used only with DMEM_ADDR_CHECK_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start_rd  in  1  read request pulse from control unit
- start_wr  in  1  write request pulse from control unit
- addr_in  in  ADDR_W  address from the address register
- wdata_in  in  DATA_W  write data from the data register
- mem_en  out  1  RAM strobe
- mem_we  out  1  RAM write enable (qualified by mem_en)
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after the final strobe cycle
- rd_data  out  DATA_W  captured read word, held until next read completes
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle error pulse

## Operation
- FSM states: IDLE, SETUP, WAIT, DONE.
- IDLE: exactly one of start_rd/start_wr high → latch addr_in, wdata_in, op type; go to SETUP. Both high → no access; err pulses the next cycle; stay IDLE.
- SETUP: mem_en=1, mem_we=1 for a write, mem_addr/mem_wdata from latches. WAIT_CYCLES=0 → DONE; otherwise → WAIT.
- WAIT: strobe held unchanged; 4-bit counter runs from 0 to WAIT_CYCLES-1, then → DONE.
- DONE: mem_en=0, mem_we=0; for a read, rd_data ← mem_rdata; done=1; → IDLE.
- Requests arriving outside IDLE are ignored: no queuing, no err.
- Latched address/data are immune to input changes after acceptance.
- mem_we never high while mem_en low.
- Reset values: mem_en, mem_we, busy, done, err = 0; mem_addr, mem_wdata, rd_data = 0; state IDLE; counter 0.
- Reset mid-access: strobe drops asynchronously, no done is issued, and rd_data is cleared.

## Timing
- Request accepted at edge N.
- Strobe is active for cycles N+1 … N+1+WAIT_CYCLES.
- done is high in cycle N+2+WAIT_CYCLES.
- Next request is accepted at the earliest in cycle N+3+WAIT_CYCLES.
- Total latency from request to done: 2+WAIT_CYCLES cycles.
- rd_data updates on the edge that ends the DONE cycle, so it is valid from cycle N+3+WAIT_CYCLES.
- All outputs are registered.

## Configuration
- DMEM_ADDR_CHECK_EN defined:
  - At acceptance, a latched address ≥ MEM_DEPTH goes to DONE directly.
  - No strobe is issued and rd_data is unchanged.
  - done and err both pulse in cycle N+1.
- Undefined: no range check. Addresses pass unmodified and MEM_DEPTH is unused.

## Structure
- Shared package: state enum (IDLE/SETUP/WAIT/DONE), op-type encoding (OP_RD/OP_WR), default widths.
- One natural sub-module, `dmem_wait_counter`: loadable down-counter with a terminal-count flag.

## Test plan
- WAIT_CYCLES=2; start_wr, addr 0x0010, data 0xBEEF → mem_en and mem_we high for 3 cycles; done at N+4; RAM[0x0010]=0xBEEF.
- Read of 0x0010 after that write → done at N+4; rd_data=0xBEEF from N+5; mem_we stays 0.
- start_rd and start_wr high together in IDLE → no mem_en; err=1 for one cycle; busy stays 0.
- start_wr to 0x0020 during an active read → ignored; RAM[0x0020] unchanged; only one done.
- reset asserted in the WAIT state → mem_en drops immediately; no done; rd_data=0; next request completes normally.
- DMEM_ADDR_CHECK_EN, MEM_DEPTH=4096; start_rd at 0x1000 → no strobe; done and err pulse in cycle N+1; rd_data unchanged.

Source files
------------

// File: rtl/data_mem_ctrl_pkg.sv
// Shared types for the data-memory access sequencer: FSM states, operation encoding,
// default widths and the wait-state counter width.
package data_mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter that times the RAM wait states; tc flags a count of zero.
module dmem_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access sequencer: latches a request, strobes the RAM for 1+WAIT_CYCLES cycles,
// then pulses done. Optional range check enabled by defining DMEM_ADDR_CHECK_EN.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = DEF_ADDR_W,
  parameter int          DATA_W      = DEF_DATA_W,
  parameter int          WAIT_CYCLES = 2,
  parameter int unsigned MEM_DEPTH   = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_rd,
  input  logic              start_wr,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_LOAD =
    CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  logic   range_err_q, range_err_d;
  logic   cnt_load, cnt_dec, cnt_tc;
  logic   one_req, both_req, addr_bad, accept, strobe_d;

  assign one_req  = start_rd ^ start_wr;
  assign both_req = start_rd & start_wr;
  assign accept   = (state_q == IDLE) && one_req;

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_bad = (32'(addr_in) >= MEM_DEPTH);
`else
  logic unused_depth;
  assign addr_bad     = 1'b0;
  assign unused_depth = (MEM_DEPTH != 0);
`endif

  dmem_wait_counter #(.CNT_W(CNT_W)) u_wait_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    range_err_d = range_err_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state_q)
      IDLE: begin
        if (one_req) begin
          op_d        = start_wr ? OP_WR : OP_RD;
          range_err_d = addr_bad;
          state_d     = addr_bad ? DONE : SETUP;
        end
      end
      SETUP: begin
        if (WAIT_CYCLES == 0) begin
          state_d = DONE;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_tc) state_d = DONE;
        else        cnt_dec = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign strobe_d = (state_d == SETUP) || (state_d == WAIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      range_err_q <= range_err_d;
    end
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_en <= strobe_d;
      mem_we <= strobe_d && (op_d == OP_WR);
      busy   <= (state_d != IDLE);
      done   <= (state_d == DONE);
      err    <= (state_q == IDLE) && (both_req || (one_req && addr_bad));
      if (accept) begin
        mem_addr  <= addr_in;
        mem_wdata <= wdata_in;
      end
      if (state_q == DONE && op_q == OP_RD && !range_err_q) begin
        rd_data <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: RAM model, behavioural reference memory, random accesses.
module tb_data_mem_ctrl;

  localparam int          WC        = 2;
  localparam int unsigned MEM_DEPTH = 4096;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_rd = 1'b0, start_wr = 1'b0;
  logic [15:0] addr_in = '0, wdata_in = '0;
  logic        mem_en, mem_we, busy, done, err;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rd_data;

  logic [15:0] ram     [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [15:0] ram_rdata = '0;
  logic [15:0] exp_rd = '0;

  int n_vec  = 0;
  int n_fail = 0;

  data_mem_ctrl #(
    .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(WC), .MEM_DEPTH(MEM_DEPTH)
  ) dut (
    .clock(clock), .reset(reset), .start_rd(start_rd), .start_wr(start_wr),
    .addr_in(addr_in), .wdata_in(wdata_in), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rd_data(rd_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rdata <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rdata;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One access; monitors strobe/done/busy/err counts over a bounded window and
  // compares them with what the timing rules predict.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input bit inject);
    int  en_cnt = 0, we_cnt = 0, we_wo_en = 0, busy_cnt = 0;
    int  done_cnt = 0, done_at = -1, err_cnt = 0, bad_bus = 0;
    bit  exp_bad = 1'b0;
`ifdef DMEM_ADDR_CHECK_EN
    exp_bad = (32'(a) >= MEM_DEPTH);
`endif
    @(negedge clock);
    start_rd = !wr; start_wr = wr; addr_in = a; wdata_in = d;
    for (int c = 1; c <= WC + 6; c++) begin
      @(negedge clock);
      if (mem_en) en_cnt++;
      if (mem_we) we_cnt++;
      if (mem_we && !mem_en) we_wo_en++;
      if (mem_en && (mem_addr != a || (wr && mem_wdata != d))) bad_bus++;
      if (busy) busy_cnt++;
      if (err) err_cnt++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      start_rd = 1'b0; start_wr = 1'b0;
      addr_in = 16'($urandom); wdata_in = 16'($urandom);
      if (inject && c == 2) begin
        start_wr = 1'b1; addr_in = 16'h0020; wdata_in = 16'h5A5A;
      end
    end
    if (!exp_bad) begin
      if (wr) ref_mem[a] = d;
      else    exp_rd = ref_mem[a];
    end
    check("strobe_cycles", en_cnt, exp_bad ? 0 : WC + 1);
    check("we_cycles", we_cnt, (wr && !exp_bad) ? WC + 1 : 0);
    check("we_without_en", we_wo_en, 0);
    check("bus_latched", bad_bus, 0);
    check("busy_cycles", busy_cnt, exp_bad ? 1 : WC + 2);
    check("done_latency", done_at, exp_bad ? 1 : WC + 2);
    check("done_count", done_cnt, 1);
    check("err_count", err_cnt, exp_bad ? 1 : 0);
    check("rd_data", rd_data, exp_rd);
    if (wr) check("ram_word", ram[a], ref_mem[a]);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'($urandom);
      ref_mem[i] = ram[i];
    end

    // Reset state
    #12;
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_busy_done_err", {busy, done, err}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rd_data", rd_data, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed write then read-back
    access(1'b1, 16'h0010, 16'hBEEF, 1'b0);
    check("ram_beef", ram[16'h0010], 16'hBEEF);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    check("rd_beef", rd_data, 16'hBEEF);

    // Simultaneous requests: err only
    @(negedge clock);
    start_rd = 1'b1; start_wr = 1'b1; addr_in = 16'h0030; wdata_in = 16'h1234;
    @(negedge clock);
    start_rd = 1'b0; start_wr = 1'b0;
    check("both_err", err, 1);
    check("both_en", mem_en, 0);
    check("both_busy", busy, 0);
    @(negedge clock);
    check("both_err_pulse", err, 0);
    check("both_idle", {mem_en, busy, done}, 0);

    // Write request during an active read must be ignored
    access(1'b0, 16'h0010, 16'h0000, 1'b1);
    check("inject_ram20", ram[16'h0020], ref_mem[16'h0020]);

    // Random traffic over a small address pool plus the range boundaries
    for (int i = 0; i < 30; i++) begin
      logic [15:0] a;
      a = 16'($urandom_range(0, 7)) * 16'h0101;
      access(1'($urandom), a, 16'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    access(1'b1, 16'h0FFF, 16'hA11C, 1'b0);
    access(1'b0, 16'h0FFF, 16'h0000, 1'b0);
    access(1'b1, 16'h1000, 16'hC0DE, 1'b0);
    access(1'b0, 16'h1000, 16'h0000, 1'b0);
    access(1'b0, 16'hFFFF, 16'h0000, 1'b0);

    // Reset in the WAIT state
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    @(negedge clock);
    start_rd = 1'b1; addr_in = 16'h0010;
    @(negedge clock);
    start_rd = 1'b0;
    @(negedge clock);
    check("pre_rst_strobe", mem_en, 1);
    reset = 1'b1;
    #1;
    check("rst_async_en", mem_en, 0);
    check("rst_async_we_busy", {mem_we, busy, done}, 0);
    check("rst_async_rd_data", rd_data, 0);
    exp_rd = '0;
    @(negedge clock);
    reset = 1'b0;
    begin
      int late = 0;
      for (int c = 0; c < WC + 4; c++) begin
        @(negedge clock);
        if (done || mem_en) late++;
      end
      check("rst_no_done", late, 0);
    end
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    access(1'b1, 16'h0042, 16'h7E57, 1'b0);
    access(1'b0, 16'h0042, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
